mdio_responder: RTL and testbench

- Clause-22 MDIO management responder, i.e. the PHY-side end of the MDIO link whose initiator drives mdc/mdio from the Ethernet core.
- Oversamples mdc/mdio in the system clock, decodes read and write frames, and serves a small PHY-style register file.
- Used as a loopback/emulation target in simulation and on-board self-test, and as the bench model for the core's MDIO master.

---
 rtl/mdio_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: oversamples mdc/mdio in clk, decodes read/write frames
// and serves a small PHY-style register file with ID and status registers.
`timescale 1ns/1ps
module mdio_responder #(
   parameter logic [4:0]  PHY_ADDR     = 5'd0,
   parameter int          NUM_REGS     = 32,
   parameter int          PREAMBLE_MIN = 32,
   parameter logic [15:0] PHY_ID1      = 16'h600D,
   parameter logic [15:0] PHY_ID2      = 16'h84A2,
   parameter logic [15:0] BMSR_BASE    = 16'h7949
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mdc,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        link_up,
   output logic        wr_strobe,
   output logic [4:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        rd_strobe,
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ST2,
      S_OP,
      S_ADDR,
      S_RD_TA,
      S_RD_DATA,
      S_WR_TA,
      S_WR_DATA,
      S_SKIP
   } state_t;

   localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

   // Synchronizers reset to the idle-high level so reset release never fakes an mdc rise.
   logic [1:0] mdc_sync_reg;
   logic [1:0] mdio_sync_reg;
   logic       mdc_prev_reg;
   logic       rise;
   logic       bit_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdc_sync_reg  <= 2'b11;
         mdio_sync_reg <= 2'b11;
         mdc_prev_reg  <= 1'b1;
      end else begin
         mdc_sync_reg  <= {mdc_sync_reg[0], mdc};
         mdio_sync_reg <= {mdio_sync_reg[0], mdio_i};
         mdc_prev_reg  <= mdc_sync_reg[1];
      end
   end

   assign rise   = mdc_sync_reg[1] & ~mdc_prev_reg;
   assign bit_in = mdio_sync_reg[1];

   state_t      state_reg;
   logic [4:0]  bit_cnt_reg;
   logic [5:0]  pre_cnt_reg;
   logic        op_first_reg;
   logic        op_read_reg;
   logic [8:0]  addr_sr_reg;
   logic [4:0]  regad_reg;
   logic [15:0] rd_sr_reg;
   logic [14:0] wr_sr_reg;
   logic        mdio_o_reg;
   logic        mdio_oe_reg;
   logic        wr_strobe_reg;
   logic [4:0]  wr_addr_reg;
   logic [15:0] wr_data_reg;
   logic        rd_strobe_reg;

   // Address field completes on the current bit at k13.
   logic [9:0]  addr_full;
   logic [4:0]  phyad_now;
   logic [4:0]  regad_now;
   assign addr_full = {addr_sr_reg, bit_in};
   assign phyad_now = addr_full[9:5];
   assign regad_now = addr_full[4:0];

   logic        commit;
   logic [15:0] commit_data;
   logic        soft_rst;
   assign commit      = rise && (state_reg == S_WR_DATA) && (bit_cnt_reg == 5'd31);
   assign commit_data = {wr_sr_reg, bit_in};
   assign soft_rst    = commit && (regad_reg == 5'd0) && commit_data[15];

   // Full 32-entry read view; unimplemented addresses read zero.
   logic [15:0] reg_view [32];

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_reg
         if (gi >= NUM_REGS) begin : g_none
            assign reg_view[gi] = 16'h0000;
         end else if (gi == 1) begin : g_bmsr
            assign reg_view[gi] = (BMSR_BASE & ~16'h0004) | {13'd0, link_up, 2'b00};
         end else if (gi == 2) begin : g_id1
            assign reg_view[gi] = PHY_ID1;
         end else if (gi == 3) begin : g_id2
            assign reg_view[gi] = PHY_ID2;
         end else begin : g_rw
            localparam logic [15:0] RST_VAL = (gi == 0) ? 16'h1140 : 16'h0000;
            logic [15:0] val_reg;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  val_reg <= RST_VAL;
               end else if (soft_rst) begin
                  val_reg <= RST_VAL;
               end else if (commit && (regad_reg == 5'(gi))) begin
                  val_reg <= commit_data;
               end
            end
            assign reg_view[gi] = val_reg;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         bit_cnt_reg   <= 5'd0;
         pre_cnt_reg   <= 6'd0;
         op_first_reg  <= 1'b0;
         op_read_reg   <= 1'b0;
         addr_sr_reg   <= 9'd0;
         regad_reg     <= 5'd0;
         rd_sr_reg     <= 16'd0;
         wr_sr_reg     <= 15'd0;
         mdio_o_reg    <= 1'b0;
         mdio_oe_reg   <= 1'b0;
         wr_strobe_reg <= 1'b0;
         wr_addr_reg   <= 5'd0;
         wr_data_reg   <= 16'd0;
         rd_strobe_reg <= 1'b0;
      end else begin
         wr_strobe_reg <= 1'b0;
         rd_strobe_reg <= 1'b0;
         if (rise) begin
            if (state_reg != S_IDLE) begin
               bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
            case (state_reg)
               S_IDLE: begin
                  if (bit_in) begin
                     if (pre_cnt_reg != 6'd32) begin
                        pre_cnt_reg <= pre_cnt_reg + 6'd1;
                     end
                  end else if (pre_cnt_reg >= PRE_MIN) begin
                     state_reg   <= S_ST2;
                     bit_cnt_reg <= 5'd1;
                     pre_cnt_reg <= 6'd0;
                  end else begin
                     pre_cnt_reg <= 6'd0;
                  end
               end
               S_ST2: begin
                  state_reg <= bit_in ? S_OP : S_IDLE;
               end
               S_OP: begin
                  if (bit_cnt_reg == 5'd2) begin
                     op_first_reg <= bit_in;
                  end else begin
                     op_read_reg <= op_first_reg;
                     state_reg   <= (op_first_reg == bit_in) ? S_SKIP : S_ADDR;
                  end
               end
               S_ADDR: begin
                  addr_sr_reg <= {addr_sr_reg[7:0], bit_in};
                  if (bit_cnt_reg == 5'd13) begin
                     regad_reg <= regad_now;
                     if (phyad_now != PHY_ADDR) begin
                        state_reg <= S_SKIP;
                     end else if (op_read_reg) begin
                        rd_sr_reg     <= reg_view[regad_now];
                        rd_strobe_reg <= 1'b1;
                        state_reg     <= S_RD_TA;
                     end else begin
                        state_reg <= S_WR_TA;
                     end
                  end
               end
               S_RD_TA: begin
                  mdio_oe_reg <= 1'b1;
                  mdio_o_reg  <= 1'b0;
                  state_reg   <= S_RD_DATA;
               end
               S_RD_DATA: begin
                  if (bit_cnt_reg == 5'd31) begin
                     mdio_oe_reg <= 1'b0;
                     mdio_o_reg  <= 1'b0;
                     state_reg   <= S_IDLE;
                  end else begin
                     mdio_o_reg <= rd_sr_reg[15];
                     rd_sr_reg  <= {rd_sr_reg[14:0], 1'b0};
                  end
               end
               S_WR_TA: begin
                  // A bad turnaround still consumes the frame so the next preamble is found cleanly.
                  if (bit_cnt_reg == 5'd14) begin
                     if (!bit_in) state_reg <= S_SKIP;
                  end else begin
                     state_reg <= bit_in ? S_SKIP : S_WR_DATA;
                  end
               end
               S_WR_DATA: begin
                  wr_sr_reg <= {wr_sr_reg[13:0], bit_in};
                  if (bit_cnt_reg == 5'd31) begin
                     wr_strobe_reg <= 1'b1;
                     wr_addr_reg   <= regad_reg;
                     wr_data_reg   <= commit_data;
                     state_reg     <= S_IDLE;
                  end
               end
               S_SKIP: begin
                  if (bit_cnt_reg == 5'd31) begin
                     state_reg <= S_IDLE;
                  end
               end
               default: begin
                  state_reg <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign mdio_o    = mdio_o_reg;
   assign mdio_oe   = mdio_oe_reg;
   assign wr_strobe = wr_strobe_reg;
   assign wr_addr   = wr_addr_reg;
   assign wr_data   = wr_data_reg;
   assign rd_strobe = rd_strobe_reg;
   assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: an MDIO initiator model drives frames, a scoreboard
// queue holds expected read data and write commits, and monitors pop and compare.
`timescale 1ns/1ps
module tb_mdio_responder;

   localparam logic [4:0] PHY = 5'd1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mdc = 1'b1;
   logic        tb_drv = 1'b1;
   logic        link_up = 1'b0;
   logic        mdio_line;
   logic        mdio_o;
   logic        mdio_oe;
   logic        wr_strobe;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic        rd_strobe;
   logic        busy;

   assign mdio_line = mdio_oe ? mdio_o : tb_drv;

   mdio_responder #(
      .PHY_ADDR(PHY),
      .NUM_REGS(8),
      .PREAMBLE_MIN(32),
      .PHY_ID1(16'h600D),
      .PHY_ID2(16'h84A2),
      .BMSR_BASE(16'h7949)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mdc(mdc),
      .mdio_i(mdio_line),
      .mdio_o(mdio_o),
      .mdio_oe(mdio_oe),
      .link_up(link_up),
      .wr_strobe(wr_strobe),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_strobe(rd_strobe),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        aborted;
   } rd_exp_t;

   rd_exp_t     rd_q[$];
   logic [20:0] wr_q[$];

   int total = 0;
   int bad = 0;
   int cur_k = -1;
   int rd_cnt = 0;
   int exp_rd = 0;
   int oe_rise_cnt = 0;
   int exp_oe = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   // One mdc period = 16 clk: low half carries the new bit, the responder samples on the rise.
   task automatic slot(input logic b);
      tb_drv = b;
      mdc = 1'b0;
      repeat (8) @(negedge clk);
      mdc = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] regad,
                        input logic [1:0] ta, input logic [15:0] data, input int npre,
                        input int abort_at);
      logic [31:0] f;
      f = {2'b01, op, phy, regad, ta, data};
      cur_k = -1;
      for (int i = 0; i < npre; i++) slot(1'b1);
      for (int i = 0; i < 32; i++) begin
         cur_k = i;
         if (i == abort_at) begin
            tb_drv = f[31-i];
            mdc = 1'b0;
            repeat (8) @(negedge clk);
            mdc = 1'b1;
            repeat (6) @(negedge clk);
            check("oe_before_rst", {31'd0, mdio_oe}, 32'd1);
            rst_n = 1'b0;
            #1;
            check("oe_async_drop", {31'd0, mdio_oe}, 32'd0);
            check("busy_in_rst", {31'd0, busy}, 32'd0);
            tb_drv = 1'b1;
            repeat (4) @(negedge clk);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            cur_k = -1;
            return;
         end
         slot(f[31-i]);
      end
      cur_k = -1;
   endtask

   task automatic rd(input logic [4:0] phy, input logic [4:0] regad, input logic [15:0] want,
                     input bit expect_resp);
      rd_exp_t e;
      if (expect_resp) begin
         e.data = want;
         e.aborted = 1'b0;
         rd_q.push_back(e);
         exp_rd++;
         exp_oe++;
      end
      frame(2'b10, phy, regad, 2'b11, 16'hFFFF, 32, -1);
   endtask

   task automatic wr(input logic [4:0] phy, input logic [4:0] regad, input logic [1:0] ta,
                     input logic [15:0] data, input bit expect_commit);
      if (expect_commit) wr_q.push_back({regad, data});
      frame(2'b01, phy, regad, ta, data, 32, -1);
   endtask

   // Read-data monitor: collects TA + 16 data bits from the bus after each drive start.
   initial begin : read_mon
      logic [16:0] got;
      logic        aborted;
      rd_exp_t     e;
      forever begin
         @(posedge mdio_oe);
         oe_rise_cnt++;
         check("oe_rise_k", cur_k, 32'd14);
         got = '0;
         aborted = 1'b0;
         for (int b = 0; b < 17; b++) begin
            @(negedge mdc or negedge mdio_oe);
            if (!mdio_oe) begin
               aborted = 1'b1;
               break;
            end
            got = {got[15:0], mdio_o};
         end
         if (!aborted) begin
            for (int t = 0; t < 40 && mdio_oe; t++) @(negedge clk);
            check("oe_fall_k", cur_k, 32'd31);
            check("oe_released", {31'd0, mdio_oe}, 32'd0);
         end
         if (rd_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got=%0h want=none", got);
         end else begin
            e = rd_q.pop_front();
            check("rd_aborted", {31'd0, aborted}, {31'd0, e.aborted});
            if (!e.aborted) check("rd_data", {15'd0, got}, {16'd0, e.data});
            $display("read  frame: bits=%05h aborted=%0d", got, aborted);
         end
      end
   end

   // Strobe monitor: counts read accepts and checks each write commit against the queue.
   initial begin : strobe_mon
      logic [20:0] w;
      forever begin
         @(negedge clk);
         if (rd_strobe) rd_cnt++;
         if (wr_strobe) begin
            if (wr_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL wr_unexpected: got=%0h want=none", {wr_addr, wr_data});
            end else begin
               w = wr_q.pop_front();
               check("wr_commit", {11'd0, wr_addr, wr_data}, {11'd0, w});
               $display("write frame: addr=%0d data=%04h", wr_addr, wr_data);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      rd_exp_t e;
      repeat (3) @(negedge clk);
      check("rst_oe", {31'd0, mdio_oe}, 32'd0);
      check("rst_o", {31'd0, mdio_o}, 32'd0);
      check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
      check("rst_rd_strobe", {31'd0, rd_strobe}, 32'd0);
      check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
      check("rst_wr_data", {16'd0, wr_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      rd(PHY, 5'd2, 16'h600D, 1);
      check("rd_strobe_once", rd_cnt, exp_rd);
      wr(PHY, 5'd4, 2'b10, 16'h01E1, 1);
      rd(PHY, 5'd4, 16'h01E1, 1);

      rd(5'd2, 5'd2, 16'h0000, 0);
      check("phy_mismatch_no_strobe", rd_cnt, exp_rd);
      rd(PHY, 5'd0, 16'h1140, 1);

      frame(2'b10, PHY, 5'd0, 2'b11, 16'hFFFF, 31, -1);
      check("short_pre_no_strobe", rd_cnt, exp_rd);
      check("short_pre_no_drive", oe_rise_cnt, exp_oe);
      wr(PHY, 5'd5, 2'b11, 16'hBEEF, 0);
      rd(PHY, 5'd5, 16'h0000, 1);

      wr(PHY, 5'd4, 2'b10, 16'h1234, 1);
      rd(PHY, 5'd4, 16'h1234, 1);
      wr(PHY, 5'd0, 2'b10, 16'h8000, 1);
      rd(PHY, 5'd4, 16'h0000, 1);
      rd(PHY, 5'd0, 16'h1140, 1);
      wr(PHY, 5'd2, 2'b10, 16'hFFFF, 1);
      rd(PHY, 5'd2, 16'h600D, 1);
      link_up = 1'b1;
      rd(PHY, 5'd1, 16'h794D, 1);
      link_up = 1'b0;
      rd(PHY, 5'd1, 16'h7949, 1);
      rd(PHY, 5'd3, 16'h84A2, 1);

      wr(PHY, 5'd7, 2'b10, 16'hA5A5, 1);
      rd(PHY, 5'd7, 16'hA5A5, 1);
      wr(PHY, 5'd10, 2'b10, 16'h5555, 1);
      rd(PHY, 5'd10, 16'h0000, 1);
      wr(PHY, 5'd0, 2'b10, 16'h0140, 1);
      rd(PHY, 5'd0, 16'h0140, 1);

      e.data = 16'h0000;
      e.aborted = 1'b1;
      rd_q.push_back(e);
      exp_rd++;
      exp_oe++;
      frame(2'b10, PHY, 5'd3, 2'b11, 16'hFFFF, 32, 20);
      rd(PHY, 5'd0, 16'h1140, 1);
      rd(PHY, 5'd7, 16'h0000, 1);

      repeat (20) @(negedge clk);
      check("final_rd_strobes", rd_cnt, exp_rd);
      check("final_oe_frames", oe_rise_cnt, exp_oe);
      check("rd_queue_empty", rd_q.size(), 32'd0);
      check("wr_queue_empty", wr_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
